load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store unit for the piRISC datapath; sits directly upstream of the RAM block.
//  Takes one load/store request per transaction from the execute stage and computes EA = base + sext(offset12).
//  Drives RAM rdEn/wrEn/isByte/isHalf/isWord, then sign/zero-extends the returned load data.
//  Returns the result to writeback over a valid/ready handshake.
// PARAMETERS
//  WIDTH       32  data/address width
//  RAM_RD_LAT  1   clk cycles from RAM rdEn sampled to rd_data valid (>=1)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      LSU can accept (high only in IDLE)
//  req_we       in   1      1=store, 0=load
//  req_funct3   in   3      RV32I funct3 (size/sign)
//  req_base     in   WIDTH  rs1 value
//  req_offset   in   12     signed immediate
//  req_wdata    in   WIDTH  rs2 value (store data)
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      writeback accepts response
//  rsp_rdata    out  WIDTH  extended load data (0 for stores and errors)
//  rsp_err      out  1      illegal funct3 or misaligned access
//  ram_wr_data  out  WIDTH  to RAM wr_data
//  ram_rd_data  in   WIDTH  from RAM rd_data: sub-word right-justified, zero-filled
//  ram_addr     out  WIDTH  to RAM addr
//  ram_rdEn / ram_wrEn             out 1 each  RAM enables
//  ram_isByte / ram_isHalf / ram_isWord  out 1 each  one-hot access size
// BEHAVIOUR
//  Reset: async on rst_n low; state=IDLE; all outputs 0 except req_ready=1. RAM enables drop immediately, even mid-access.
//  FSM: IDLE -> ACCESS -> (store: RESP) | (load: WAIT x RAM_RD_LAT -> RESP) -> IDLE.
//  IDLE: on req_valid&&req_ready, register EA, funct3, we, wdata, and goto ACCESS.
//  ACCESS: exactly one cycle. Drive ram_addr=EA and the size one-hot, plus ram_wrEn=1 (store) or ram_rdEn=1 (load).
//  ACCESS also drives ram_wr_data=wdata unchanged; the RAM uses the low bits for sub-word stores.
//  WAIT: hold ram_addr and size; count down RAM_RD_LAT; capture ram_rd_data in the final WAIT cycle.
//  RESP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready; on handshake goto IDLE.
//   rsp_valid never depends combinationally on rsp_ready.
//  Latency: store accepted at edge N -> rsp_valid at N+2; load -> N+2+RAM_RD_LAT.
//  EA: modulo-2^WIDTH add; 0xFFFFFFFC + (-4 -> +8) wraps to 0x00000004. No overflow flag.
//  funct3 decode:
//   loads:  000 LB (sext b7), 001 LH (sext b15), 010 LW, 100 LBU, 101 LHU.
//   stores: 000 SB, 001 SH, 010 SW.
//   Any other code: no RAM enable asserted; ACCESS goes straight to RESP with rsp_err=1, rsp_rdata=0.
//  Size one-hot is exactly one of isByte/isHalf/isWord whenever any RAM enable is high, else all 0.
//  rdEn and wrEn are never high together.
//  Errors respond at store latency (N+2).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   half with EA[0]=1, or word with EA[1:0]!=0, asserts no RAM enable.
//   The access completes as an error: rsp_err=1, rsp_rdata=0, store latency.
//  Not defined:
//   EA is force-aligned (half clears EA[0], word clears EA[1:0]) and the access proceeds normally.
//   Misalignment is then never an error.
// STRUCTURE
//  lsu_defs.vh: funct3 localparams (F3_B/H/W/BU/HU), FSM state encodings (S_IDLE/S_ACCESS/S_WAIT/S_RESP).
//  Sub-module lsu_load_extend: combinational funct3 + raw RAM data -> extended WIDTH result.
//  FSM, EA adder, wait counter and response registers stay in the top.
// TESTING
//  SW base=0 off=0 wdata=0xDEADBEEF -> ACCESS: wrEn=1, isWord=1, addr=0; rsp_valid 2 cycles after accept; err=0.
//  LB addr 0x8, RAM returns 0x00000080 -> rsp_rdata=0xFFFFFF80; LBU same data -> 0x00000080.
//  LH/LHU, RAM returns 0x0000F00F -> 0xFFFFF00F / 0x0000F00F; latency 2+RAM_RD_LAT (also RAM_RD_LAT=3).
//  LW base=0x2 off=0 -> TRAP_EN: no rdEn, rsp_err=1. Without: ram_addr=0x0, err=0.
//  funct3=011 load or 100 store -> no RAM enables, rsp_err=1, rsp_rdata=0.
//  Hold rsp_ready=0 5 cycles -> rsp_* stable, req_ready=0.
//   Then pulse rst_n low during a WAIT -> enables 0 at once, IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the piRISC load/store unit: RV32I funct3 size codes
// and the LSU sequencer states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_e;

  // One-hot {word, half, byte} from funct3; all-zero for the reserved size code.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size = 3'b001;
      2'b01:   f3_size = 3'b010;
      2'b10:   f3_size = 3'b100;
      default: f3_size = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load-data extension: turns right-justified, zero-filled RAM read data into
// the sign- or zero-extended register value selected by funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{(WIDTH-8){i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_data = {{(WIDTH-16){i_raw[15]}}, i_raw[15:0]};
      F3_BU:   o_data = {{(WIDTH-8){1'b0}}, i_raw[7:0]};
      F3_HU:   o_data = {{(WIDTH-16){1'b0}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// piRISC memory-stage load/store unit: EA generation, RAM sequencing and load
// extension. Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses
// into error responses; otherwise the EA is force-aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RAM_RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_base,
  input  logic [11:0]      req_offset,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [WIDTH-1:0] ram_wr_data,
  input  logic [WIDTH-1:0] ram_rd_data,
  output logic [WIDTH-1:0] ram_addr,
  output logic             ram_rdEn,
  output logic             ram_wrEn,
  output logic             ram_isByte,
  output logic             ram_isHalf,
  output logic             ram_isWord
);

  localparam int CNT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ea;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic [2:0]       r_f3;
  logic             r_we;
  logic             r_err;

  logic [WIDTH-1:0] w_ea_sum;
  logic [WIDTH-1:0] w_addr;
  logic [WIDTH-1:0] w_ext;
  logic [2:0]       w_size;
  logic             w_legal;
  logic             w_go;

  assign w_ea_sum = req_base + {{(WIDTH-12){req_offset[11]}}, req_offset};

  lsu_load_extend #(.WIDTH(WIDTH)) u_ext (
    .i_funct3 (r_f3),
    .i_raw    (ram_rd_data),
    .o_data   (w_ext)
  );

  // Decode of the registered request; w_go means a RAM access really happens.
  always_comb begin
    w_size  = f3_size(r_f3);
    w_legal = r_we ? (r_f3 inside {F3_B, F3_H, F3_W})
                   : (r_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_addr  = r_ea;
`ifdef LSU_MISALIGN_TRAP_EN
    w_go    = w_legal && !((w_size[1] && r_ea[0]) || (w_size[2] && (r_ea[1:0] != 2'b00)));
`else
    w_go    = w_legal;
    if (w_size[1]) w_addr[0]   = 1'b0;
    if (w_size[2]) w_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_ACCESS;
      S_ACCESS: w_next = (w_go && !r_we) ? S_WAIT : S_RESP;
      S_WAIT:   if (r_cnt == '0) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Every output is decoded from state so reset clears it without waiting for a clock.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    rsp_valid   = (r_state == S_RESP);
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    ram_wr_data = '0;
    ram_addr    = '0;
    ram_rdEn    = 1'b0;
    ram_wrEn    = 1'b0;
    ram_isByte  = 1'b0;
    ram_isHalf  = 1'b0;
    ram_isWord  = 1'b0;
    case (r_state)
      S_ACCESS: begin
        ram_addr    = w_addr;
        ram_wr_data = r_wdata;
        if (w_go) begin
          {ram_isWord, ram_isHalf, ram_isByte} = w_size;
          ram_wrEn = r_we;
          ram_rdEn = !r_we;
        end
      end
      S_WAIT: begin
        ram_addr = w_addr;
        {ram_isWord, ram_isHalf, ram_isByte} = w_size;
      end
      S_RESP: begin
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ACCESS)
        r_cnt <= CNT_W'(RAM_RD_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Request and response payload; only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_ea    <= w_ea_sum;
      r_f3    <= req_funct3;
      r_we    <= req_we;
      r_wdata <= req_wdata;
    end
    if (r_state == S_ACCESS) begin
      r_err   <= !w_go;
      r_rdata <= '0;
    end
    if (r_state == S_WAIT && r_cnt == '0)
      r_rdata <= w_ext;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table on a RAM_RD_LAT=1 instance,
// plus stall, RAM_RD_LAT=3 and async-reset sequences on a second instance.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid3, rsp_ready, rsp_ready3;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_wdata, ram_rd_data;
  logic [11:0] req_offset;

  logic        req_ready, rsp_valid, rsp_err, ram_rdEn, ram_wrEn, ram_isByte, ram_isHalf, ram_isWord;
  logic [31:0] rsp_rdata, ram_wr_data, ram_addr;
  logic        req_ready3, rsp_valid3, rsp_err3, ram_rdEn3, ram_wrEn3, ram_isByte3, ram_isHalf3, ram_isWord3;
  logic [31:0] rsp_rdata3, ram_wr_data3, ram_addr3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .RAM_RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .ram_addr(ram_addr),
    .ram_rdEn(ram_rdEn), .ram_wrEn(ram_wrEn), .ram_isByte(ram_isByte), .ram_isHalf(ram_isHalf),
    .ram_isWord(ram_isWord)
  );

  load_store_unit #(.WIDTH(32), .RAM_RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .ram_wr_data(ram_wr_data3), .ram_rd_data(ram_rd_data), .ram_addr(ram_addr3),
    .ram_rdEn(ram_rdEn3), .ram_wrEn(ram_wrEn3), .ram_isByte(ram_isByte3), .ram_isHalf(ram_isHalf3),
    .ram_isWord(ram_isWord3)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic        e_rd;
    logic        e_wr;
    logic [2:0]  e_size;   // {isWord, isHalf, isByte} during ACCESS
    int          e_lat;    // accept edge N -> rsp_valid sampled at edge N+e_lat
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input string nm, input logic we, input logic [2:0] f3,
                              input logic [31:0] base, input logic [11:0] off,
                              input logic [31:0] wdata, input logic [31:0] rd,
                              input logic [31:0] e_addr, input logic e_rd, input logic e_wr,
                              input logic [2:0] e_size, input int e_lat,
                              input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata; v.rd = rd;
    v.e_addr = e_addr; v.e_rd = e_rd; v.e_wr = e_wr; v.e_size = e_size; v.e_lat = e_lat;
    v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    req_we = v.we; req_funct3 = v.f3; req_base = v.base; req_offset = v.off;
    req_wdata = v.wdata; ram_rd_data = v.rd; rsp_ready = 1'b1; req_valid = 1'b1;
    #1 chk({v.name, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk({v.name, ".addr"},    ram_addr, v.e_addr);
    chk({v.name, ".rdEn"},    {31'b0, ram_rdEn}, {31'b0, v.e_rd});
    chk({v.name, ".wrEn"},    {31'b0, ram_wrEn}, {31'b0, v.e_wr});
    chk({v.name, ".size"},    {29'b0, ram_isWord, ram_isHalf, ram_isByte}, {29'b0, v.e_size});
    chk({v.name, ".wr_data"}, ram_wr_data, v.wdata);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1 k++;
    end
    chk({v.name, ".latency"}, k + 1, v.e_lat);
    chk({v.name, ".rdata"},   rsp_rdata, v.e_rdata);
    chk({v.name, ".err"},     {31'b0, rsp_err}, {31'b0, v.e_err});
    @(posedge clk);
    #1 chk({v.name, ".back_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b000; req_base = '0; req_offset = '0; req_wdata = '0;
    ram_rd_data = '0;

    vt[0]  = mk("SW",       1, 3'b010, 32'h0,        12'h000, 32'hDEADBEEF, 32'h0,      32'h0,  0, 1, 3'b100, 2, 32'h0,        0);
    vt[1]  = mk("LB",       0, 3'b000, 32'h8,        12'h000, 32'h55,       32'h80,     32'h8,  1, 0, 3'b001, 3, 32'hFFFFFF80, 0);
    vt[2]  = mk("LBU",      0, 3'b100, 32'h8,        12'h000, 32'h55,       32'h80,     32'h8,  1, 0, 3'b001, 3, 32'h00000080, 0);
    vt[3]  = mk("LH",       0, 3'b001, 32'h10,       12'h002, 32'h55,       32'hF00F,   32'h12, 1, 0, 3'b010, 3, 32'hFFFFF00F, 0);
    vt[4]  = mk("LHU",      0, 3'b101, 32'h10,       12'h002, 32'h55,       32'hF00F,   32'h12, 1, 0, 3'b010, 3, 32'h0000F00F, 0);
    vt[5]  = mk("LW_negoff",0, 3'b010, 32'h100,      12'hFFC, 32'h55,       32'h12345678, 32'hFC, 1, 0, 3'b100, 3, 32'h12345678, 0);
    vt[6]  = mk("SW_wrap",  1, 3'b010, 32'hFFFFFFFC, 12'h008, 32'hA5A5A5A5, 32'h0,      32'h4,  0, 1, 3'b100, 2, 32'h0,        0);
    vt[7]  = mk("SB",       1, 3'b000, 32'h20,       12'h001, 32'h11223344, 32'h0,      32'h21, 0, 1, 3'b001, 2, 32'h0,        0);
    vt[8]  = mk("SH",       1, 3'b001, 32'h20,       12'h002, 32'h11223344, 32'h0,      32'h22, 0, 1, 3'b010, 2, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
    vt[9]  = mk("LW_mis",   0, 3'b010, 32'h2,        12'h000, 32'h55,       32'hCAFEF00D, 32'h2,  0, 0, 3'b000, 2, 32'h0,      1);
    vt[10] = mk("LH_mis",   0, 3'b001, 32'h31,       12'h000, 32'h55,       32'h7FFF,   32'h31, 0, 0, 3'b000, 2, 32'h0,        1);
`else
    vt[9]  = mk("LW_mis",   0, 3'b010, 32'h2,        12'h000, 32'h55,       32'hCAFEF00D, 32'h0,  1, 0, 3'b100, 3, 32'hCAFEF00D, 0);
    vt[10] = mk("LH_mis",   0, 3'b001, 32'h31,       12'h000, 32'h55,       32'h7FFF,   32'h30, 1, 0, 3'b010, 3, 32'h00007FFF, 0);
`endif
    vt[11] = mk("L_f3_011", 0, 3'b011, 32'h44,       12'h000, 32'h55,       32'hFFFFFFFF, 32'h44, 0, 0, 3'b000, 2, 32'h0,      1);
    vt[12] = mk("S_f3_100", 1, 3'b100, 32'h48,       12'h000, 32'h77,       32'hFFFFFFFF, 32'h48, 0, 0, 3'b000, 2, 32'h0,      1);

    #12;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.enables",   {30'b0, ram_rdEn, ram_wrEn}, 32'd0);
    chk("rst.addr",      ram_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vt[i]);

    // Back-pressure: response must hold while writeback stalls.
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b000; req_base = 32'h8; req_offset = '0;
    ram_rd_data = 32'h80; rsp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1 k++; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall.rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall.rdata",     rsp_rdata, 32'hFFFFFF80);
      chk("stall.req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall.release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("stall.release_ready", {31'b0, req_ready}, 32'd1);

    // RAM_RD_LAT=3 instance: load latency 2+3.
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b001; req_base = 32'h10; req_offset = 12'h002;
    ram_rd_data = 32'hF00F; rsp_ready3 = 1'b1; req_valid3 = 1'b1;
    @(posedge clk); #1 req_valid3 = 1'b0;
    chk("lat3.rdEn", {31'b0, ram_rdEn3}, 32'd1);
    k = 0;
    while (!rsp_valid3 && k < 20) begin @(posedge clk); #1 k++; end
    chk("lat3.latency", k + 1, 5);
    chk("lat3.rdata",   rsp_rdata3, 32'hFFFFF00F);
    @(posedge clk); #1;

    // Async reset in WAIT: held address and size drop at once.
    @(negedge clk);
    req_funct3 = 3'b010; req_base = 32'h40; req_offset = '0; req_valid3 = 1'b1;
    @(posedge clk); #1 req_valid3 = 1'b0;
    chk("rstw.access_addr", ram_addr3, 32'h40);
    @(posedge clk); #1;
    chk("rstw.wait_addr",   ram_addr3, 32'h40);
    chk("rstw.wait_word",   {31'b0, ram_isWord3}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw.addr_drop",   ram_addr3, 32'h0);
    chk("rstw.size_drop",   {29'b0, ram_isWord3, ram_isHalf3, ram_isByte3}, 32'd0);
    chk("rstw.req_ready",   {31'b0, req_ready3}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw.idle_ready",  {31'b0, req_ready3}, 32'd1);
    chk("rstw.no_rsp",      {31'b0, rsp_valid3}, 32'd0);

    // Async reset in ACCESS: rdEn drops without a clock edge.
    @(negedge clk) req_valid3 = 1'b1;
    @(posedge clk); #1 req_valid3 = 1'b0;
    chk("rsta.rdEn_before", {31'b0, ram_rdEn3}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rsta.rdEn_drop", {31'b0, ram_rdEn3}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rsta.idle_ready",  {31'b0, req_ready3}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
